// File: rtl/seven_segment_scan_driver.sv
// Multiplexed seven-segment scan driver: one digit lit per slot, with dead cycles against ghosting.
// Define SEVSEG_LZB_EN to blank leading zeros above the most significant nonzero digit.
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    hex_mode,
  input  logic                    blank,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    scan_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              code;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   oneHot;

  function automatic logic [6:0] decode(input logic [3:0] c, input logic hex);
    logic [6:0] g;
    g = 7'b0000000;
    case (c)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1110011;
      4'hA: g = hex ? 7'b1110111 : 7'b0000000;
      4'hB: g = hex ? 7'b0011111 : 7'b0000000;
      4'hC: g = hex ? 7'b1001110 : 7'b0000000;
      4'hD: g = hex ? 7'b0111101 : 7'b0000000;
      4'hE: g = hex ? 7'b1001111 : 7'b0000000;
      4'hF: g = hex ? 7'b1000111 : 7'b0000000;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

`ifdef SEVSEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzMask;

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin : lzScan
    logic zeroAbove;
    zeroAbove = 1'b1;
    lzMask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeroAbove = zeroAbove && (value_q[4*i +: 4] == 4'd0);
      lzMask[i] = zeroAbove;
    end
  end
`endif

  always_comb begin
    code = value_q[4*idx +: 4];
    glyph = decode(code, hex_mode);
`ifdef SEVSEG_LZB_EN
    if (lzMask[idx]) glyph = 7'b0000000;
`endif
    oneHot = '0;
    oneHot[idx] = 1'b1;
  end

  // Outputs are computed from the current slot state, so they trail cnt/idx by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q   <= '0;
      dp_q      <= '0;
      cnt       <= '0;
      idx       <= '0;
      segments  <= '0;
      dp_out    <= 1'b0;
      digit_en  <= '0;
      scan_tick <= 1'b0;
    end else begin
      if (load) begin
        value_q <= value;
        dp_q    <= dp;
      end
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        scan_tick <= 1'b1;
      end else begin
        cnt       <= cnt + 1'b1;
        scan_tick <= 1'b0;
      end
      if (blank) begin
        segments <= '0;
        dp_out   <= 1'b0;
        digit_en <= '0;
      end else begin
        segments <= glyph;
        dp_out   <= dp_q[idx];
        digit_en <= (cnt >= CNT_DEAD) ? oneHot : '0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver: stimulus queues one expected entry per slot,
// a negedge monitor pops it on every scan_tick. Honours SEVSEG_LZB_EN for leading-zero expectations.
module tb_seven_segment_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GB = 7'b0011111;
  localparam logic [6:0] GC = 7'b1001110;
  localparam logic [6:0] GD = 7'b0111101;
  localparam logic [6:0] GOFF = 7'b0000000;
`ifdef SEVSEG_LZB_EN
  localparam logic [6:0] GLZ = 7'b0000000;
`else
  localparam logic [6:0] GLZ = 7'b1111110;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   value = '0;
  logic          load = 1'b0;
  logic [3:0]    dp = '0;
  logic          hex_mode = 1'b0;
  logic          blank = 1'b0;
  logic [6:0]    segments;
  logic          dp_out;
  logic [3:0]    digit_en;
  logic          scan_tick;

  seven_segment_scan_driver #(
    .NUM_DIGITS(ND),
    .SCAN_DIV(SD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .dp(dp),
    .hex_mode(hex_mode),
    .blank(blank),
    .segments(segments),
    .dp_out(dp_out),
    .digit_en(digit_en),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dpo;
    logic [3:0] en;
    int         zeros;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int period = 0;
  int zeroCnt = 0;
  exp_t mon;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [6:0] seg, input logic dpo, input logic [3:0] en,
                              input int zeros, input string name);
    exp_t e;
    e.seg = seg;
    e.dpo = dpo;
    e.en = en;
    e.zeros = zeros;
    e.name = name;
    sbq.push_back(e);
  endtask

  // Monitor: one scoreboard entry per slot, compared in the slot's last cycle.
  always @(negedge clk) begin
    if (rst) begin
      period = 0;
      zeroCnt = 0;
    end else begin
      period++;
      if (digit_en == 4'b0000) zeroCnt++;
      checkOutput("onehot", 32'($countones(digit_en) > 1), 32'd0);
      if (scan_tick) begin
        checkOutput("unexpectedTick", 32'(sbq.size() == 0), 32'd0);
        if (sbq.size() != 0) begin
          mon = sbq.pop_front();
          checkOutput({mon.name, "_seg"}, 32'(segments), 32'(mon.seg));
          checkOutput({mon.name, "_dp"}, 32'(dp_out), 32'(mon.dpo));
          checkOutput({mon.name, "_en"}, 32'(digit_en), 32'(mon.en));
          checkOutput({mon.name, "_period"}, period, SD);
          checkOutput({mon.name, "_dead"}, zeroCnt, mon.zeros);
        end
        period = 0;
        zeroCnt = 0;
      end
    end
  end

  task automatic waitSlotEnd(input string name);
    for (int n = 0; n < 4 * SD; n++) begin
      @(posedge clk);
      #1;
      if (scan_tick) break;
    end
    checkOutput({name, "_tickSeen"}, 32'(scan_tick), 32'd1);
  endtask

  // Starts right after the previous slot's tick; inputs take effect from the next slot's first edge.
  task automatic applyStimulus(input logic doLoad, input logic [15:0] v, input logic [3:0] d,
                               input logic hm, input logic bl, input logic [6:0] expSeg,
                               input logic expDp, input logic [3:0] expEn, input int zeros,
                               input logic checkLatency, input logic [6:0] oldSeg,
                               input string name);
    hex_mode = hm;
    blank = bl;
    if (doLoad) begin
      value = v;
      dp = d;
      load = 1'b1;
    end
    pushExpected(expSeg, expDp, expEn, zeros, name);
    @(posedge clk);
    #1;
    load = 1'b0;
    if (bl) checkOutput({name, "_blankNext"}, 32'({segments, dp_out, digit_en}), 32'd0);
    if (checkLatency) begin
      checkOutput({name, "_captureEdge"}, 32'(segments), 32'(oldSeg));
      @(posedge clk);
      #1;
      checkOutput({name, "_nextEdge"}, 32'(segments), 32'(expSeg));
    end
    waitSlotEnd(name);
  endtask

  task automatic releaseReset(input logic [6:0] expSeg, input string name);
    int edges;
    edges = 0;
    pushExpected(expSeg, 1'b0, 4'b0001, DC, name);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      load = 1'b0;
      edges = n;
      if (digit_en != 4'b0000) break;
    end
    checkOutput({name, "_firstEnEdge"}, edges, DC + 1);
    checkOutput({name, "_firstEn"}, 32'(digit_en), 32'd1);
    waitSlotEnd(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutputs", 32'({segments, dp_out, digit_en, scan_tick}), 32'd0);

    value = 16'h1234;
    load = 1'b1;
    releaseReset(G4, "s0_1234");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, G3, 1'b0, 4'b0010, DC, 1'b0, GOFF, "s1_1234");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, G2, 1'b0, 4'b0100, DC, 1'b0, GOFF, "s2_1234");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, G1, 1'b0, 4'b1000, DC, 1'b0, GOFF, "s3_1234");

    applyStimulus(1'b1, 16'hABCD, 4'h0, 1'b1, 1'b0, GD, 1'b0, 4'b0001, DC, 1'b1, G4, "s0_hexWrap");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, GC, 1'b0, 4'b0010, DC, 1'b0, GOFF, "s1_hex");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, GB, 1'b0, 4'b0100, DC, 1'b0, GOFF, "s2_hex");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, GA, 1'b0, 4'b1000, DC, 1'b0, GOFF, "s3_hex");

    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, GOFF, 1'b0, 4'b0001, DC, 1'b0, GOFF, "s0_noHex");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, GOFF, 1'b0, 4'b0010, DC, 1'b0, GOFF, "s1_noHex");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, GOFF, 1'b0, 4'b0100, DC, 1'b0, GOFF, "s2_noHex");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, GOFF, 1'b0, 4'b1000, DC, 1'b0, GOFF, "s3_noHex");

    applyStimulus(1'b1, 16'h0050, 4'b0100, 1'b0, 1'b0, G0, 1'b0, 4'b0001, DC, 1'b0, GOFF, "s0_0050");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, GOFF, 1'b0, 4'b0000, SD, 1'b0, GOFF, "s1_blank");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, GLZ, 1'b1, 4'b0100, DC, 1'b0, GOFF, "s2_unblank");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, GLZ, 1'b0, 4'b1000, DC, 1'b0, GOFF, "s3_0050");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, G0, 1'b0, 4'b0001, DC, 1'b0, GOFF, "s0_0050b");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, G5, 1'b0, 4'b0010, DC, 1'b0, GOFF, "s1_0050b");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, GLZ, 1'b1, 4'b0100, DC, 1'b0, GOFF, "s2_0050b");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, GLZ, 1'b0, 4'b1000, DC, 1'b0, GOFF, "s3_0050b");

    @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midSlotReset", 32'({segments, dp_out, digit_en, scan_tick}), 32'd0);
    repeat (2) @(posedge clk);
    releaseReset(G0, "s0_afterReset");

    @(negedge clk);
    #1;
    checkOutput("scoreboardDrained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
